// File: rtl/stream_frame_ctrl.sv
// Raster-order frame sequencer: fetches one colour per pixel and emits AXI4-Stream video beats.
// Optional build macro SQUARE_PATTERN_EN replaces pix_rgb with an internal blue-square test pattern.
module stream_frame_ctrl #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int X_W   = 10,
    parameter int Y_W   = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           continuous,
    input  logic           stop,
    output logic           busy,
    output logic           frame_done,
    output logic [15:0]    frame_count,
    output logic           pix_req,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    input  logic [23:0]    pix_rgb,
    output logic [31:0]    out_stream_tdata,
    output logic [3:0]     out_stream_tkeep,
    output logic           out_stream_tlast,
    input  logic           out_stream_tready,
    output logic           out_stream_tvalid,
    output logic           out_stream_tuser
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    state_t      state, state_next;
    logic        ld, accept, x_last, y_last, frame_last;
    logic        eof_flag, stop_pending;
    logic [23:0] rgb_sel;

    assign x_last     = (pix_x == X_LAST);
    assign y_last     = (pix_y == Y_LAST);
    assign frame_last = x_last && y_last;
    assign accept     = out_stream_tvalid && out_stream_tready;
    assign ld         = (state == RUN) && (!out_stream_tvalid || out_stream_tready);

    assign pix_req          = ld;
    assign busy             = (state != IDLE);
    assign frame_done       = accept && eof_flag;
    assign out_stream_tkeep = 4'hF;

`ifdef SQUARE_PATTERN_EN
    localparam logic [X_W-1:0] SQ_X0 = X_W'(H_RES / 4);
    localparam logic [X_W-1:0] SQ_X1 = X_W'(3 * H_RES / 4);
    localparam logic [Y_W-1:0] SQ_Y0 = Y_W'(V_RES / 4);
    localparam logic [Y_W-1:0] SQ_Y1 = Y_W'(3 * V_RES / 4);

    logic unused_rgb;
    assign unused_rgb = ^pix_rgb;
    assign rgb_sel = (pix_x >= SQ_X0 && pix_x < SQ_X1 && pix_y >= SQ_Y0 && pix_y < SQ_Y1)
                     ? 24'h0000FF : 24'h000000;
`else
    assign rgb_sel = pix_rgb;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Continuous mode re-enters (0,0) straight from RUN so frames abut with no bubble.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (ld && frame_last && !(continuous && !stop_pending)) state_next = DRAIN;
            DRAIN:   if (accept && eof_flag) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A stop in the same cycle as start from IDLE still yields exactly one frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_pending <= 1'b0;
        end else if (state == IDLE) begin
            stop_pending <= start && stop;
        end else if (state_next == IDLE) begin
            stop_pending <= 1'b0;
        end else if (stop) begin
            stop_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_x             <= '0;
            pix_y             <= '0;
            out_stream_tdata  <= '0;
            out_stream_tvalid <= 1'b0;
            out_stream_tuser  <= 1'b0;
            out_stream_tlast  <= 1'b0;
            eof_flag          <= 1'b0;
        end else if (ld) begin
            out_stream_tdata  <= {8'h00, rgb_sel};
            out_stream_tvalid <= 1'b1;
            out_stream_tuser  <= (pix_x == '0) && (pix_y == '0);
            out_stream_tlast  <= x_last;
            eof_flag          <= frame_last;
            if (x_last) begin
                pix_x <= '0;
                pix_y <= y_last ? '0 : pix_y + 1'b1;
            end else begin
                pix_x <= pix_x + 1'b1;
            end
        end else if (accept) begin
            out_stream_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count <= '0;
        end else if (frame_done) begin
            frame_count <= frame_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_frame_ctrl.sv
// Self-checking bench for stream_frame_ctrl: cycle tables for single frames plus scored multi-frame runs.
// With SQUARE_PATTERN_EN defined it uses an 8x4 frame and checks the blue-square pattern instead.
module tb_stream_frame_ctrl;

`ifdef SQUARE_PATTERN_EN
    localparam int H = 8;
    localparam int V = 4;
`else
    localparam int H = 4;
    localparam int V = 3;
`endif
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        stop = 1'b0;
    logic        tready = 1'b1;
    logic        busy, frame_done, pix_req;
    logic [15:0] frame_count;
    logic [9:0]  pix_x, pix_y;
    logic [23:0] pix_rgb;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast, tvalid, tuser;

    int vectors = 0;
    int miscompares = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    // The pixel source answers with {y, x} one byte each; the square build must ignore it.
`ifdef SQUARE_PATTERN_EN
    always_comb pix_rgb = {8'hAA, pix_y[7:0], pix_x[7:0]};
`else
    always_comb pix_rgb = {8'h00, pix_y[7:0], pix_x[7:0]};
`endif

    stream_frame_ctrl #(.H_RES(H), .V_RES(V), .X_W(10), .Y_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
        .out_stream_tready(tready), .out_stream_tvalid(tvalid), .out_stream_tuser(tuser)
    );

    typedef struct packed {
        logic        busy;
        logic        pix_req;
        logic        tvalid;
        logic        tuser;
        logic        tlast;
        logic        frame_done;
        logic [15:0] count;
        logic [31:0] tdata;
    } obs_t;

    typedef struct {
        logic st;
        logic sp;
        logic co;
        logic tr;
        obs_t exp;
    } vec_t;

    vec_t vecs[$];

    function automatic obs_t sample();
        obs_t o;
        o = '{busy, pix_req, tvalid, tuser, tlast, frame_done, frame_count, tdata};
        return o;
    endfunction

    // Reference colour for a coordinate, written independently of the DUT.
    function automatic logic [23:0] exp_rgb(input int x, input int y);
`ifdef SQUARE_PATTERN_EN
        return (x >= 2 && x <= 5 && y >= 1 && y <= 2) ? 24'h0000FF : 24'h000000;
`else
        return {8'h00, 8'(y), 8'(x)};
`endif
    endfunction

    function automatic void add(input logic st, input logic sp, input logic co, input logic tr,
                                input logic b, input logic pr, input logic tv, input logic tu,
                                input logic tl, input logic fd, input logic [15:0] c,
                                input logic [31:0] d);
        vec_t v;
        v.st = st; v.sp = sp; v.co = co; v.tr = tr;
        v.exp = '{b, pr, tv, tu, tl, fd, c, d};
        vecs.push_back(v);
    endfunction

    task automatic apply_stimulus(input logic st, input logic sp, input logic co, input logic tr);
        start = st; stop = sp; continuous = co; tready = tr;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs from a start pulse until the block returns to IDLE, scoring every accepted beat.
    task automatic run_frames(input string name, input logic cont, input bit start_with_stop,
                              input int frames, input int stop_beat, input int start_beat,
                              input bit bp);
        int  beats = 0;
        int  fds = 0;
        int  gaps = 0;
        int  cyc = 0;
        bit  seen = 0;
        bit  done = 0;
        int  i, x, y;
        logic [33:0] exp_beat;
        apply_stimulus(1'b1, start_with_stop, cont, 1'b1);
        #2;
        next_cycle();
        while (!done && cyc < 20 * N + 50) begin
            apply_stimulus(beats == start_beat, beats == stop_beat, cont,
                           bp ? ($urandom_range(0, 3) != 0) : 1'b1);
            #2;
            if (tvalid && tready) begin
                i = beats % N;
                x = i % H;
                y = i / H;
                exp_beat = {i == 0, x == H - 1, 8'h00, exp_rgb(x, y)};
                check_output($sformatf("%s beat%0d", name, beats), 64'({tuser, tlast, tdata}),
                             64'(exp_beat));
                if (i == N - 1)
                    check_output($sformatf("%s done%0d", name, beats), 64'(frame_done), 64'd1);
                beats++;
            end else if (seen && beats < frames * N && !tvalid) begin
                gaps++;
            end
            if (frame_done) fds++;
            if (tvalid) seen = 1;
            next_cycle();
            cyc++;
            if (seen && !busy) done = 1;
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        exp_count += frames;
        check_output({name, " finished"}, 64'(done), 64'd1);
        check_output({name, " beats"}, 64'(beats), 64'(frames * N));
        check_output({name, " done pulses"}, 64'(fds), 64'(frames));
        check_output({name, " gaps"}, 64'(gaps), 64'd0);
        check_output({name, " count"}, 64'(frame_count), 64'(exp_count[15:0]));
        repeat (4) next_cycle();
        check_output({name, " stays idle"}, 64'({busy, tvalid}), 64'd0);
    endtask

    initial begin
        obs_t rst_obs;
        rst_obs = '0;

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        repeat (2) next_cycle();
        check_output("reset state", 64'(sample()), 64'(rst_obs));
        check_output("reset tkeep", 64'(tkeep), 64'hF);
        rst = 1'b1;

`ifndef SQUARE_PATTERN_EN
        // Single frame, tready always high: one beat per cycle starting two cycles after start.
        add(1,0,0,1, 0,0,0,0,0,0, 16'd0, 32'h000000);
        add(0,0,0,1, 1,1,0,0,0,0, 16'd0, 32'h000000);
        add(0,0,0,1, 1,1,1,1,0,0, 16'd0, 32'h000000);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd0, 32'h000001);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd0, 32'h000002);
        add(0,0,0,1, 1,1,1,0,1,0, 16'd0, 32'h000003);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd0, 32'h000100);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd0, 32'h000101);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd0, 32'h000102);
        add(0,0,0,1, 1,1,1,0,1,0, 16'd0, 32'h000103);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd0, 32'h000200);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd0, 32'h000201);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd0, 32'h000202);
        add(0,0,0,1, 1,0,1,0,1,1, 16'd0, 32'h000203);
        add(0,0,0,1, 0,0,0,0,1,0, 16'd1, 32'h000203);
        // Second frame with tready low for three cycles while beat 5 is presented.
        add(1,0,0,1, 0,0,0,0,1,0, 16'd1, 32'h000203);
        add(0,0,0,1, 1,1,0,0,1,0, 16'd1, 32'h000203);
        add(0,0,0,1, 1,1,1,1,0,0, 16'd1, 32'h000000);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd1, 32'h000001);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd1, 32'h000002);
        add(0,0,0,1, 1,1,1,0,1,0, 16'd1, 32'h000003);
        add(0,0,0,0, 1,0,1,0,0,0, 16'd1, 32'h000100);
        add(0,0,0,0, 1,0,1,0,0,0, 16'd1, 32'h000100);
        add(0,0,0,0, 1,0,1,0,0,0, 16'd1, 32'h000100);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd1, 32'h000100);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd1, 32'h000101);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd1, 32'h000102);
        add(0,0,0,1, 1,1,1,0,1,0, 16'd1, 32'h000103);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd1, 32'h000200);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd1, 32'h000201);
        add(0,0,0,1, 1,1,1,0,0,0, 16'd1, 32'h000202);
        add(0,0,0,1, 1,0,1,0,1,1, 16'd1, 32'h000203);
        add(0,0,0,1, 0,0,0,0,1,0, 16'd2, 32'h000203);
        // Stop in IDLE is ignored and must not leak into the next start.
        add(0,1,0,1, 0,0,0,0,1,0, 16'd2, 32'h000203);
        add(0,0,0,1, 0,0,0,0,1,0, 16'd2, 32'h000203);

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].st, vecs[k].sp, vecs[k].co, vecs[k].tr);
            #2;
            check_output($sformatf("vec%0d", k), 64'(sample()), 64'(vecs[k].exp));
            next_cycle();
        end
        exp_count = 2;
`endif

        run_frames("cont_stop", 1'b1, 1'b0, 2, N + 5, -1, 1'b0);
        run_frames("start_busy", 1'b0, 1'b0, 1, -1, 3, 1'b0);
        run_frames("start_busy_bp", 1'b0, 1'b0, 1, -1, 7, 1'b1);
        run_frames("start_stop", 1'b1, 1'b1, 1, -1, -1, 1'b0);

        // Reset asserted while the seventh beat is on the bus.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        next_cycle();
        start = 1'b0;
        repeat (7) next_cycle();
        #2;
        check_output("beat7 before reset", 64'({tvalid, tdata}),
                     64'({1'b1, 8'h00, exp_rgb(6 % H, 6 / H)}));
        rst = 1'b0;
        #1;
        check_output("async reset", 64'(sample()), 64'(rst_obs));
        next_cycle();
        check_output("held in reset", 64'(sample()), 64'(rst_obs));
        rst = 1'b1;
        exp_count = 0;
        run_frames("after_reset", 1'b0, 1'b0, 1, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
